hist_align_accumulator: RTL and testbench

- Step-4 stage directly downstream of the PE histogram.
- Consumes one beat of 16 signed per-exponent bins (bin k = net signed count of products with exponent sum k) per handshake and accumulates bins across beats until IN_LAST.
- Then aligns the bins (weight 2^k) and reduces them serially to a single signed dot-product result.
- Returns the result through a valid/ready output port.

---
 rtl/hist_align_accumulator_if.sv | 35 +++
 rtl/hist_align_accumulator.sv | 120 ++++++++++++
 tb/tb_hist_align_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_align_accumulator_if.sv
// ============================================================================
// Module   : hist_align_accumulator_if
// Brief    : Beat-input / result-output handshake bundle for the align stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hist_align_accumulator_if #(
    parameter int MAX_BEATS = 16,
    parameter int RES_W     = 26
);
    localparam int c_bw = $clog2(MAX_BEATS) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [15:0][5:0]        in_bins;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [RES_W-1:0] result;
    logic [c_bw-1:0]         out_beats;
    logic                    overflow;

    modport slave (
        input  in_valid, in_bins, in_last, out_ready,
        output in_ready, out_valid, result, out_beats, overflow
    );

    modport master (
        output in_valid, in_bins, in_last, out_ready,
        input  in_ready, out_valid, result, out_beats, overflow
    );
endinterface

`default_nettype wire

// File: rtl/hist_align_accumulator.sv
// ============================================================================
// Module   : hist_align_accumulator
// Brief    : Accumulates per-exponent bins over a beat group, then reduces
//            them MSB-first (Horner) into one signed dot-product result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hist_align_accumulator #(
    parameter int MAX_BEATS = 16,
    parameter int ACC_W     = 10,
    parameter int RES_W     = 26
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    hist_align_accumulator_if.slave    bus
);
    localparam int              c_bw  = $clog2(MAX_BEATS) + 1;
    localparam logic [c_bw-1:0] c_max = c_bw'(MAX_BEATS);
    localparam logic [c_bw-1:0] c_one = c_bw'(1);

    typedef enum logic [1:0] {
        S_ACCUM  = 2'd0,
        S_REDUCE = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc [16];
    logic [c_bw-1:0]         r_beat_cnt;
    logic                    r_ovf_sticky;
    logic [3:0]              r_idx;
    logic signed [RES_W-1:0] r_red;
    logic signed [RES_W-1:0] r_result;
    logic [c_bw-1:0]         r_out_beats;
    logic                    r_overflow;
    logic                    r_in_ready;
    logic                    r_out_valid;

    logic                    w_accept;
    logic signed [RES_W-1:0] w_red_next;

    assign w_accept = bus.in_valid && r_in_ready && (r_state == S_ACCUM);

    // One Horner step: shift the partial sum up one exponent, add the next lower bin.
    always_comb begin
        w_red_next = (r_red <<< 1)
                   + {{(RES_W-ACC_W){r_acc[r_idx][ACC_W-1]}}, r_acc[r_idx]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_ACCUM;
            for (int k = 0; k < 16; k++) r_acc[k] <= '0;
            r_beat_cnt   <= '0;
            r_ovf_sticky <= 1'b0;
            r_idx        <= 4'd0;
            r_red        <= '0;
            r_result     <= '0;
            r_out_beats  <= '0;
            r_overflow   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        for (int k = 0; k < 16; k++) begin
                            r_acc[k] <= r_acc[k]
                                      + {{(ACC_W-6){bus.in_bins[k][5]}}, bus.in_bins[k]};
                        end
                        if (r_beat_cnt == c_max) r_ovf_sticky <= 1'b1;
                        else                     r_beat_cnt   <= r_beat_cnt + c_one;
                        if (bus.in_last) begin
                            r_state    <= S_REDUCE;
                            r_idx      <= 4'd15;
                            r_red      <= '0;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_REDUCE: begin
                    r_red <= w_red_next;
                    r_idx <= r_idx - 4'd1;
                    if (r_idx == 4'd0) begin
                        r_state     <= S_OUTPUT;
                        r_result    <= w_red_next;
                        r_out_beats <= r_beat_cnt;
                        r_overflow  <= r_ovf_sticky;
                        r_out_valid <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        r_state      <= S_ACCUM;
                        for (int k = 0; k < 16; k++) r_acc[k] <= '0;
                        r_beat_cnt   <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_out_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.out_beats = r_out_beats;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_hist_align_accumulator.sv
// ============================================================================
// Module   : tb_hist_align_accumulator
// Brief    : Self-checking bench with a bin-sum reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hist_align_accumulator;
    localparam int MAX_BEATS = 16;
    localparam int ACC_W     = 10;
    localparam int RES_W     = 26;
    localparam int BW        = $clog2(MAX_BEATS) + 1;

    typedef logic [15:0][5:0] bins_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hist_align_accumulator_if #(.MAX_BEATS(MAX_BEATS), .RES_W(RES_W)) bus ();

    hist_align_accumulator #(.MAX_BEATS(MAX_BEATS), .ACC_W(ACC_W), .RES_W(RES_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain integer bin totals and beat count for the open group.
    longint m_acc [16];
    int     m_beats;
    bit     m_ovf;

    function automatic void model_clear();
        for (int k = 0; k < 16; k++) m_acc[k] = 0;
        m_beats = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_beat(input bins_t b);
        for (int k = 0; k < 16; k++) m_acc[k] += longint'($signed(b[k]));
        if (m_beats >= MAX_BEATS) m_ovf = 1'b1;
        else                      m_beats++;
    endfunction

    function automatic logic signed [RES_W-1:0] model_result();
        longint s;
        s = 0;
        for (int k = 0; k < 16; k++) s += m_acc[k] * (longint'(1) << k);
        return s[RES_W-1:0];
    endfunction

    function automatic bins_t rand_bins();
        bins_t b;
        for (int k = 0; k < 16; k++) begin
            int v;
            v = int'($urandom_range(32)) - 16;
            b[k] = v[5:0];
        end
        return b;
    endfunction

    function automatic bins_t one_bin(input int k, input int v);
        bins_t b;
        b = '0;
        b[k] = v[5:0];
        return b;
    endfunction

    task automatic send_beat(input bins_t b, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bins  = b;
        bus.in_last  = last;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_beat_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        @(posedge clk);
        model_beat(b);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the LAST beat is accepted; checks latency, values, hold, handshake.
    task automatic expect_result(input string name, input int hold);
        logic signed [RES_W-1:0] e_res;
        logic [BW-1:0]           e_beats;
        logic                    e_ovf;
        logic signed [RES_W-1:0] got_res;
        int lat;
        bit rdy_seen;
        e_res   = model_result();
        e_beats = BW'(m_beats);
        e_ovf   = m_ovf;
        lat = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
        n_cmp++;
        if (lat !== 16) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges required 16", name, lat);
        end
        n_cmp++;
        if (rdy_seen !== 1'b0) begin
            n_err++;
            $display("FAIL %s_in_ready_busy: got in_ready=1 during reduce required 0", name);
        end
        got_res = bus.result;
        n_cmp++;
        if (got_res !== e_res) begin
            n_err++;
            $display("FAIL %s_result: got %0d required %0d", name, got_res, e_res);
        end
        n_cmp++;
        if ({bus.out_beats, bus.overflow} !== {e_beats, e_ovf}) begin
            n_err++;
            $display("FAIL %s_beats_ovf: got beats=%0d ovf=%0b required beats=%0d ovf=%0b",
                     name, bus.out_beats, bus.overflow, e_beats, e_ovf);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, e_res}) begin
                n_err++;
                $display("FAIL %s_hold%0d: got valid=%0b ready=%0b result=%0d required 1 0 %0d",
                         name, i, bus.out_valid, bus.in_ready, bus.result, e_res);
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL %s_release: got ready=%0b valid=%0b required 1 0",
                     name, bus.in_ready, bus.out_valid);
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_bins = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.out_beats, bus.overflow}
            !== {1'b1, 1'b0, {RES_W{1'b0}}, {BW{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got ready=%0b valid=%0b result=%0d beats=%0d ovf=%0b required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.out_beats, bus.overflow);
        end
    endtask

    task automatic test_single();
        bins_t b;
        b = one_bin(0, 1);
        b[15] = 6'h3f;
        send_beat(b, 1'b1);
        expect_result("single", 0);
        n_cmp++;
        if (bus.result !== -26'sd32767) begin
            n_err++;
            $display("FAIL single_const: got %0d required -32767", bus.result);
        end
    endtask

    task automatic test_three_beats();
        send_beat(one_bin(3, 16), 1'b0);
        send_beat(one_bin(3, 16), 1'b0);
        send_beat(one_bin(3, 16), 1'b1);
        // Beat offered while busy must be ignored.
        bus.in_valid = 1'b1;
        bus.in_bins  = rand_bins();
        bus.in_last  = 1'b1;
        expect_result("three", 0);
        n_cmp++;
        if (bus.result !== 26'sd384) begin
            n_err++;
            $display("FAIL three_const: got %0d required 384", bus.result);
        end
    endtask

    task automatic test_mixed();
        bins_t p, n;
        for (int k = 0; k < 16; k++) begin
            p[k] = 6'd16;
            n[k] = 6'h30;
        end
        send_beat(p, 1'b0);
        send_beat(n, 1'b1);
        expect_result("mixed", 0);
        n_cmp++;
        if (bus.result !== '0) begin
            n_err++;
            $display("FAIL mixed_const: got %0d required 0", bus.result);
        end
    endtask

    task automatic test_full_and_overflow();
        for (int i = 0; i < 16; i++) send_beat(one_bin(15, 16), i == 15);
        expect_result("full16", 0);
        n_cmp++;
        if ({bus.result, bus.overflow} !== {26'sd8388608, 1'b0}) begin
            n_err++;
            $display("FAIL full16_const: got %0d ovf=%0b required 8388608 0", bus.result, bus.overflow);
        end
        for (int i = 0; i < 17; i++) send_beat(one_bin(15, 16), i == 16);
        expect_result("overflow17", 0);
        n_cmp++;
        if ({bus.out_beats, bus.overflow} !== {5'd16, 1'b1}) begin
            n_err++;
            $display("FAIL overflow17_const: got beats=%0d ovf=%0b required 16 1", bus.out_beats, bus.overflow);
        end
    endtask

    task automatic test_zero_group();
        send_beat('0, 1'b1);
        expect_result("zero", 0);
    endtask

    task automatic test_backpressure();
        send_beat(rand_bins(), 1'b1);
        expect_result("bp", 5);
        send_beat(one_bin(1, 2), 1'b1);
        expect_result("bp_next", 0);
        n_cmp++;
        if (bus.result !== 26'sd4) begin
            n_err++;
            $display("FAIL bp_next_const: got %0d required 4", bus.result);
        end
    endtask

    task automatic test_reset_abort();
        send_beat(rand_bins(), 1'b0);
        send_beat(rand_bins(), 1'b1);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.out_beats, bus.overflow}
            !== {1'b1, 1'b0, {RES_W{1'b0}}, {BW{1'b0}}, 1'b0}) begin
            n_err++;
            $display("FAIL abort_values: got ready=%0b valid=%0b result=%0d beats=%0d ovf=%0b required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.out_beats, bus.overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_ready: got %0b required 1", bus.in_ready);
        end
        send_beat(rand_bins(), 1'b1);
        expect_result("abort_next", 0);
    endtask

    task automatic test_random();
        for (int g = 0; g < 12; g++) begin
            int nb;
            nb = int'($urandom_range(1, MAX_BEATS));
            for (int i = 0; i < nb; i++) send_beat(rand_bins(), i == nb - 1);
            expect_result("random", int'($urandom_range(3)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_beats();
        test_mixed();
        test_full_and_overflow();
        test_zero_group();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
